// File: rtl/counter_run_ctrl.sv
// Run controller for a modulo-MODULUS counter with command handshake and round limit.
// Optional down counting is enabled by defining COUNT_DOWN_EN (adds input up_dn).
module counter_run_ctrl #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 5,
    parameter int ROUNDS_W = 4
) (
    input  logic                clock1,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [WIDTH-1:0]    cmd_data,
    input  logic [ROUNDS_W-1:0] rounds,
    input  logic                step,
`ifdef COUNT_DOWN_EN
    input  logic                up_dn,
`endif
    output logic [WIDTH-1:0]    count,
    output logic                tc,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [1:0]          state, state_n;
    logic [WIDTH-1:0]    count_n;
    logic [ROUNDS_W-1:0] rcnt, rcnt_n, rlim, rlim_n, rcnt_inc;
    logic                err_n, tc_n;
    logic                accept, up, at_end, data_ok, can_load;
    logic                is_start, is_stop, is_clear, is_load;

    assign accept   = cmd_valid && cmd_ready;
    assign is_start = cmd_op == OP_START;
    assign is_stop  = cmd_op == OP_STOP;
    assign is_clear = cmd_op == OP_CLEAR;
    assign is_load  = cmd_op == OP_LOAD;

`ifdef COUNT_DOWN_EN
    assign up = up_dn;
`else
    assign up = 1'b1;
`endif

    assign at_end   = up ? (count == LAST) : (count == '0);
    assign rcnt_inc = rcnt + 1'b1;
    assign data_ok  = {1'b0, cmd_data} < MOD_W;
    assign can_load = (state == S_IDLE) || (state == S_PAUSE);

    always_comb begin
        state_n = state;
        count_n = count;
        rcnt_n  = rcnt;
        rlim_n  = rlim;
        err_n   = err;
        tc_n    = 1'b0;
        if (accept) begin
            // an accepted command always swallows a same-cycle step
            unique case (1'b1)
                is_start: begin
                    case (state)
                        S_IDLE: begin
                            state_n = S_RUN;
                            rlim_n  = rounds;
                        end
                        S_PAUSE: state_n = S_RUN;
                        S_DONE: begin
                            state_n = S_RUN;
                            count_n = '0;
                            rcnt_n  = '0;
                            rlim_n  = rounds;
                        end
                        default: ;
                    endcase
                end
                is_stop: begin
                    if (state == S_RUN) state_n = S_PAUSE;
                end
                is_clear: begin
                    state_n = S_IDLE;
                    count_n = '0;
                    rcnt_n  = '0;
                    err_n   = 1'b0;
                end
                is_load: begin
                    if (can_load && data_ok) count_n = cmd_data;
                    else                     err_n   = 1'b1;
                end
                default: ;
            endcase
        end else if (step && state == S_RUN) begin
            if (at_end) begin
                count_n = up ? '0 : LAST;
                tc_n    = 1'b1;
                rcnt_n  = rcnt_inc;
                if (rlim != '0 && rcnt_inc == rlim) state_n = S_DONE;
            end else begin
                count_n = up ? count + 1'b1 : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock1) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            rcnt      <= '0;
            rlim      <= '0;
            tc        <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            rcnt      <= rcnt_n;
            rlim      <= rlim_n;
            tc        <= tc_n;
            err       <= err_n;
            cmd_ready <= 1'b1;
        end
    end

    assign busy = state == S_RUN;
    assign done = state == S_DONE;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl: directed plan then random traffic
// against an abstract reference model.
module tb_counter_run_ctrl;

    localparam int WIDTH    = 3;
    localparam int MODULUS  = 5;
    localparam int ROUNDS_W = 4;

    typedef enum int { M_IDLE, M_RUN, M_PAUSE, M_DONE } mstate_t;

    typedef struct {
        int    count;
        bit    tc;
        bit    busy;
        bit    done;
        bit    err;
        bit    rdy;
        string tag;
    } exp_t;

    logic                clock1;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [WIDTH-1:0]    cmd_data;
    logic [ROUNDS_W-1:0] rounds;
    logic                step;
    logic                up_dn;
    logic [WIDTH-1:0]    count;
    logic                tc;
    logic                busy;
    logic                done;
    logic                err;

    counter_run_ctrl #(
        .WIDTH(WIDTH),
        .MODULUS(MODULUS),
        .ROUNDS_W(ROUNDS_W)
    ) dut (
        .clock1(clock1),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .rounds(rounds),
        .step(step),
`ifdef COUNT_DOWN_EN
        .up_dn(up_dn),
`endif
        .count(count),
        .tc(tc),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial begin
        clock1 = 1'b0;
        forever #5 clock1 = ~clock1;
    end

    exp_t    sb[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    bit      drv_done = 0;

    mstate_t m_state = M_IDLE;
    int      m_count = 0;
    int      m_rcnt  = 0;
    int      m_rlim  = 0;
    bit      m_err   = 0;
    bit      m_rdy   = 0;
    bit      m_tc    = 0;

    localparam int ST = 0, SP = 1, CL = 2, LD = 3;

    // Reference model: effect of one clock edge given the inputs.
    task automatic model(input bit r, input bit v, input int op,
                         input int d, input int rn, input bit s,
                         input bit u);
        int nxt;
        bit upc;
`ifdef COUNT_DOWN_EN
        upc = u;
`else
        upc = 1'b1;
`endif
        m_tc = 0;
        if (r) begin
            m_state = M_IDLE;
            m_count = 0;
            m_rcnt  = 0;
            m_rlim  = 0;
            m_err   = 0;
            m_rdy   = 0;
            return;
        end
        if (v && m_rdy) begin
            if (op == ST) begin
                if (m_state == M_IDLE) begin
                    m_state = M_RUN;
                    m_rlim  = rn;
                end else if (m_state == M_PAUSE) begin
                    m_state = M_RUN;
                end else if (m_state == M_DONE) begin
                    m_state = M_RUN;
                    m_count = 0;
                    m_rcnt  = 0;
                    m_rlim  = rn;
                end
            end else if (op == SP) begin
                if (m_state == M_RUN) m_state = M_PAUSE;
            end else if (op == CL) begin
                m_state = M_IDLE;
                m_count = 0;
                m_rcnt  = 0;
                m_err   = 0;
            end else begin
                if ((m_state == M_IDLE || m_state == M_PAUSE) && d < MODULUS)
                    m_count = d;
                else
                    m_err = 1;
            end
        end else if (s && m_state == M_RUN) begin
            nxt = upc ? m_count + 1 : m_count - 1;
            if (nxt >= MODULUS || nxt < 0) begin
                m_count = upc ? 0 : MODULUS - 1;
                m_tc    = 1;
                m_rcnt  = (m_rcnt + 1) % (1 << ROUNDS_W);
                if (m_rlim != 0 && m_rcnt == m_rlim) m_state = M_DONE;
            end else begin
                m_count = nxt;
            end
        end
        m_rdy = 1;
    endtask

    task automatic cyc(input bit r, input bit v, input int op, input int d,
                       input int rn, input bit s, input bit u,
                       input string tag);
        exp_t e;
        rst       = r;
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_data  = WIDTH'(d);
        rounds    = ROUNDS_W'(rn);
        step      = s;
        up_dn     = u;
        model(r, v, op, d, rn, s, u);
        e.count = m_count;
        e.tc    = m_tc;
        e.busy  = (m_state == M_RUN);
        e.done  = (m_state == M_DONE);
        e.err   = m_err;
        e.rdy   = m_rdy;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clock1);
    endtask

    task automatic idle(input bit s, input string tag);
        cyc(0, 0, 0, 0, 0, s, 1, tag);
    endtask

    task automatic cmd(input int op, input int d, input int rn, input bit s,
                       input string tag);
        cyc(0, 1, op, d, rn, s, 1, tag);
    endtask

    initial begin : driver
        int r, v, op, d, rn, s, u;
        cyc(1, 0, 0, 0, 0, 0, 1, "reset0");
        cyc(1, 1, ST, 0, 0, 1, 1, "reset1");
        idle(0, "ready_rise");
        idle(0, "ready_hi");

        cmd(CL, 0, 0, 0, "p1_clear");
        cmd(ST, 0, 0, 1, "p1_start");
        for (int i = 0; i < 12; i++) idle(1, "p1_steps");

        cmd(CL, 0, 0, 0, "p2_clear");
        cmd(ST, 0, 2, 0, "p2_start");
        for (int i = 0; i < 12; i++) idle(1, "p2_rounds");

        cmd(CL, 0, 0, 0, "p3_clear");
        cmd(ST, 0, 0, 0, "p3_start");
        for (int i = 0; i < 3; i++) idle(1, "p3_steps");
        cmd(SP, 0, 0, 1, "p3_stop_step");
        idle(1, "p3_paused");
        cmd(ST, 0, 0, 1, "p3_resume");
        idle(1, "p3_step");

        cmd(CL, 0, 0, 0, "p4_clear");
        cmd(LD, 6, 0, 0, "p4_load_bad");
        cmd(CL, 0, 0, 0, "p4_clear_err");
        cmd(LD, 4, 0, 0, "p4_load4");
        cmd(ST, 0, 0, 0, "p4_start");
        idle(1, "p4_wrap");
        idle(0, "p4_after");

        cmd(CL, 0, 0, 0, "p5_clear");
        cmd(ST, 0, 0, 0, "p5_start");
        for (int i = 0; i < 4; i++) idle(1, "p5_steps");
        cyc(1, 1, ST, 0, 0, 1, 1, "p5_rst");
        idle(1, "p5_ready");
        idle(1, "p5_idle");

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1 && op == ST && v)
                op = $urandom_range(0, 3);
            d  = $urandom_range(0, (1 << WIDTH) - 1);
            rn = ($urandom_range(0, 3) == 0) ?
                 $urandom_range(0, (1 << ROUNDS_W) - 1) : $urandom_range(0, 3);
            s  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            cyc(r[0], v[0], op, d, rn, s[0], u[0], "random");
        end
        drv_done = 1;
    end

    initial begin : monitor
        exp_t e;
        bit   ok;
        for (int k = 0; k < 200000; k++) begin
            @(posedge clock1);
            #1;
            if (sb.size() == 0) begin
                if (drv_done) break;
                n_checks++;
                n_fail++;
                $display("FAIL no_expect: output seen with empty scoreboard");
                continue;
            end
            e  = sb.pop_front();
            ok = (int'(count) == e.count) && (tc === e.tc) &&
                 (busy === e.busy) && (done === e.done) &&
                 (err === e.err) && (cmd_ready === e.rdy);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b err=%b rdy=%b, expected count=%0d tc=%b busy=%b done=%b err=%b rdy=%b",
                         e.tag, count, tc, busy, done, err, cmd_ready,
                         e.count, e.tc, e.busy, e.done, e.err, e.rdy);
            end
        end
        if (!drv_done || sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: driver or scoreboard did not drain");
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
